// File: rtl/lmem_ctrl.sv
// Load-side data memory controller: issues word reads, stalls MEM, extracts/extends byte or halfword.
// Optional misaligned-load exception path is enabled by defining LOAD_ADDR_EXC_EN.

`ifndef LB_CONTROL
`define LB_CONTROL  6'h20
`endif
`ifndef LH_CONTROL
`define LH_CONTROL  6'h21
`endif
`ifndef LW_CONTROL
`define LW_CONTROL  6'h23
`endif
`ifndef LBU_CONTROL
`define LBU_CONTROL 6'h24
`endif
`ifndef LHU_CONTROL
`define LHU_CONTROL 6'h25
`endif

module lmem_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ld_valid,
    input  logic [5:0]  ld_op,
    input  logic [31:0] ld_addr,
    input  logic        flush,
    output logic        data_sram_req,
    output logic [31:0] data_sram_addr,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        stall,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        laddrerr,
    output logic [31:0] badvaddr
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] CANCEL = 3'd4;
`ifdef LOAD_ADDR_EXC_EN
    localparam logic [2:0] ERR    = 3'd5;
`endif

    logic [2:0]  state;
    logic [2:0]  nextState;
    logic [5:0]  opReg;
    logic [31:0] addrReg;
    logic        legalOp;
    logic        misaligned;
    logic        startLoad;
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic [31:0] extracted;

    always_comb begin
        legalOp = 1'b0;
        case (ld_op)
            `LB_CONTROL, `LBU_CONTROL, `LH_CONTROL, `LHU_CONTROL, `LW_CONTROL: legalOp = 1'b1;
            default: legalOp = 1'b0;
        endcase
    end

`ifdef LOAD_ADDR_EXC_EN
    always_comb begin
        misaligned = 1'b0;
        case (ld_op)
            `LH_CONTROL, `LHU_CONTROL: misaligned = ld_addr[0];
            `LW_CONTROL:               misaligned = |ld_addr[1:0];
            default:                   misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign startLoad = (state == IDLE) && ld_valid && legalOp;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (startLoad) begin
`ifdef LOAD_ADDR_EXC_EN
                    nextState = misaligned ? ERR : REQ;
`else
                    nextState = REQ;
`endif
                end
            end
            // A flush racing addr_ok still owes us a data beat, so it must be drained.
            REQ: begin
                if (flush)
                    nextState = data_sram_addr_ok ? CANCEL : IDLE;
                else if (data_sram_addr_ok)
                    nextState = WAIT;
            end
            WAIT: begin
                if (data_sram_data_ok)
                    nextState = flush ? IDLE : DONE;
                else if (flush)
                    nextState = CANCEL;
            end
            CANCEL: begin
                if (data_sram_data_ok)
                    nextState = IDLE;
            end
            DONE:    nextState = IDLE;
`ifdef LOAD_ADDR_EXC_EN
            ERR:     nextState = IDLE;
`endif
            default: nextState = IDLE;
        endcase
    end

    // Big-endian lane order: offset 0 is the most significant byte.
    always_comb begin
        byteLane = data_sram_rdata[31:24];
        case (addrReg[1:0])
            2'b00: byteLane = data_sram_rdata[31:24];
            2'b01: byteLane = data_sram_rdata[23:16];
            2'b10: byteLane = data_sram_rdata[15:8];
            2'b11: byteLane = data_sram_rdata[7:0];
            default: byteLane = data_sram_rdata[31:24];
        endcase
        halfLane = addrReg[1] ? data_sram_rdata[15:0] : data_sram_rdata[31:16];
    end

    always_comb begin
        extracted = data_sram_rdata;
        case (opReg)
            `LB_CONTROL:  extracted = {{24{byteLane[7]}}, byteLane};
            `LBU_CONTROL: extracted = {24'b0, byteLane};
            `LH_CONTROL:  extracted = {{16{halfLane[15]}}, halfLane};
            `LHU_CONTROL: extracted = {16'b0, halfLane};
            default:      extracted = data_sram_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            opReg   <= 6'b0;
            addrReg <= 32'b0;
            result  <= 32'b0;
        end else begin
            state <= nextState;
            if (startLoad) begin
                opReg   <= ld_op;
                addrReg <= ld_addr;
            end
            if ((state == WAIT) && data_sram_data_ok && !flush)
                result <= extracted;
        end
    end

    assign data_sram_req  = (state == REQ);
    assign data_sram_addr = {addrReg[31:2], 2'b00};
    assign result_valid   = (state == DONE);
    assign stall          = (startLoad && !misaligned) || (state == REQ) ||
                            (state == WAIT) || (state == CANCEL);

`ifdef LOAD_ADDR_EXC_EN
    assign laddrerr = (state == ERR);
    assign badvaddr = (state == ERR) ? addrReg : 32'b0;
`else
    assign laddrerr = 1'b0;
    assign badvaddr = 32'b0;
`endif

endmodule
